// File: rtl/servo_ramp_ctrl.sv
// Servo position controller: round-robin command arbitration, range clamp, and
// per-frame slew-limited updates of the PWM generator's high-time register.
module servo_ramp_ctrl #(
  parameter int WIDTH_W = 17,
  parameter int MIN_W   = 50_000,
  parameter int MAX_W   = 100_000,
  parameter int CENTER  = 75_000,
  parameter int STEP    = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic [WIDTH_W-1:0] cmd_a,
  input  logic               req_b,
  input  logic [WIDTH_W-1:0] cmd_b,
  output logic               gnt_a,
  output logic               gnt_b,
  input  logic               frame_end,
  output logic [WIDTH_W-1:0] width_out,
  output logic               width_load,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  localparam logic [WIDTH_W-1:0] MIN_V  = WIDTH_W'(MIN_W);
  localparam logic [WIDTH_W-1:0] MAX_V  = WIDTH_W'(MAX_W);
  localparam logic [WIDTH_W-1:0] CTR_V  = WIDTH_W'(CENTER);
  localparam logic [WIDTH_W-1:0] STEP_V = WIDTH_W'(STEP);

  logic [1:0]         state, state_nxt;
  logic [WIDTH_W-1:0] target, target_nxt, width_nxt;
  logic [WIDTH_W-1:0] cmd_sel, cmd_clamp, diff, stepped;
  logic               rr_b, sample_ok, grant_a, grant_b;

  // No sampling in the grant cycle: the requester is still dropping its req.
  always_comb begin
    sample_ok = ~(gnt_a | gnt_b);
    grant_a   = sample_ok & req_a & (~req_b | ~rr_b);
    grant_b   = sample_ok & req_b & (~req_a |  rr_b);
    cmd_sel   = grant_b ? cmd_b : cmd_a;
    if (cmd_sel < MIN_V)      cmd_clamp = MIN_V;
    else if (cmd_sel > MAX_V) cmd_clamp = MAX_V;
    else                      cmd_clamp = cmd_sel;
    target_nxt = (grant_a | grant_b) ? cmd_clamp : target;
  end

  // Slew uses the target registered before this edge; never overshoots.
  always_comb begin
    if (target > width_out) begin
      diff    = target - width_out;
      stepped = (diff <= STEP_V) ? target : width_out + STEP_V;
    end else begin
      diff    = width_out - target;
      stepped = (diff <= STEP_V) ? target : width_out - STEP_V;
    end
  end

  always_comb begin
    state_nxt = state;
    width_nxt = width_out;
    case (state)
      IDLE: if (target_nxt != width_out) state_nxt = WAIT;
      WAIT: begin
        if (frame_end) begin
          width_nxt = stepped;
          state_nxt = LOAD;
        end else if (target_nxt == width_out) begin
          state_nxt = IDLE;
        end
      end
      LOAD:    state_nxt = (target_nxt != width_out) ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign width_load = (state == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= CTR_V;
      width_out <= CTR_V;
      busy      <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      rr_b      <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      width_out <= width_nxt;
      busy      <= (width_nxt != target_nxt);
      gnt_a     <= grant_a;
      gnt_b     <= grant_b;
      if (grant_a)      rr_b <= 1'b1;
      else if (grant_b) rr_b <= 1'b0;
    end
  end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: load scoreboard fed by a reference slew model,
// table-driven clamp vectors, and hand sequences for arbitration/reset/overlap.
module tb_servo_ramp_ctrl;
  localparam int W = 17;

  logic         clk = 0, rst = 0;
  logic         req_a = 0, req_b = 0, frame_end = 0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic         gnt_a, gnt_b, width_load, busy;
  logic [W-1:0] width_out;

  servo_ramp_ctrl dut (
    .clk(clk), .rst(rst), .req_a(req_a), .cmd_a(cmd_a), .req_b(req_b),
    .cmd_b(cmd_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .frame_end(frame_end),
    .width_out(width_out), .width_load(width_load), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_loads = 0;
  int exp_q[$];
  int model_w = 75000, model_t = 75000;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampf(input int c);
    if (c < 50000) return 50000;
    if (c > 100000) return 100000;
    return c;
  endfunction

  function automatic int stepf(input int w, input int t);
    if (t > w) return (t - w <= 500) ? t : w + 500;
    return (w - t <= 500) ? t : w - 500;
  endfunction

  // Scoreboard: every width_load must match the next modelled width.
  always @(negedge clk) begin
    if (width_load) begin
      n_loads++;
      if (exp_q.size() == 0) check("unexpected_load", int'(width_out), -1);
      else check("load_width", int'(width_out), exp_q.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    model_w = 75000; model_t = 75000;
  endtask

  task automatic req(input bit is_b, input int cmd);
    bit got = 0;
    @(negedge clk);
    if (is_b) begin req_b = 1; cmd_b = W'(cmd); end
    else      begin req_a = 1; cmd_a = W'(cmd); end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt_a | gnt_b) got = 1;
    end
    if (!got) check("gnt_timeout", 0, 1);
    check("gnt_sel", {30'd0, gnt_b, gnt_a}, is_b ? 2 : 1);
    req_a = 0; req_b = 0;
    model_t = clampf(cmd);
    @(negedge clk);
    check("gnt_pulse", {30'd0, gnt_b, gnt_a}, 0);
    check("busy_after_cmd", int'(busy), int'(model_w != model_t));
  endtask

  task automatic frame();
    @(negedge clk); frame_end = 1;
    if (model_w != model_t) begin
      model_w = stepf(model_w, model_t);
      exp_q.push_back(model_w);
    end
    @(negedge clk); frame_end = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ramp_done(input string name, input int exp_final);
    for (int i = 0; i < 400 && model_w != model_t; i++) frame();
    frame();
    check({name, "_width"}, int'(width_out), exp_final);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  typedef struct {
    bit is_b;
    int cmd;
    int exp_final;
  } vec_t;

  vec_t vecs[5];
  int l0;

  initial begin
    vecs[0] = '{1'b1, 20000, 50000};
    vecs[1] = '{1'b0, 120000, 100000};
    vecs[2] = '{1'b1, 75000, 75000};
    vecs[3] = '{1'b0, 99999, 99999};
    vecs[4] = '{1'b1, 50000, 50000};

    // 1: reset state, then silence across 5 frames
    do_reset();
    check("rst_width", int'(width_out), 75000);
    check("rst_busy", int'(busy), 0);
    check("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
    l0 = n_loads;
    repeat (5) frame();
    check("rst_no_loads", n_loads - l0, 0);

    // 3: simultaneous requests, round-robin from a fresh pointer
    @(negedge clk); req_a = 1; cmd_a = W'(60000); req_b = 1; cmd_b = W'(90000);
    @(negedge clk); check("dual1_first", {30'd0, gnt_a, gnt_b}, 2); req_a = 0;
    @(negedge clk); check("dual1_blackout", {30'd0, gnt_a, gnt_b}, 0);
    @(negedge clk); check("dual1_second", {30'd0, gnt_a, gnt_b}, 1); req_b = 0;
    @(negedge clk); check("dual1_idle", {30'd0, gnt_a, gnt_b}, 0);
    model_t = 90000;
    req(1'b0, 90000);
    @(negedge clk); req_a = 1; cmd_a = W'(60000); req_b = 1; cmd_b = W'(90000);
    @(negedge clk); check("dual2_first", {30'd0, gnt_a, gnt_b}, 1); req_b = 0;
    @(negedge clk); check("dual2_blackout", {30'd0, gnt_a, gnt_b}, 0);
    @(negedge clk); check("dual2_second", {30'd0, gnt_a, gnt_b}, 2); req_a = 0;
    model_t = 60000;
    ramp_done("dual2", 60000);

    // 2: 10-frame ramp 75000 -> 80000
    do_reset();
    req(1'b0, 80000);
    l0 = n_loads;
    repeat (10) frame();
    check("ramp10_loads", n_loads - l0, 10);
    check("ramp10_width", int'(width_out), 80000);
    check("ramp10_busy", int'(busy), 0);
    frame();
    check("ramp10_no_11th", n_loads - l0, 10);

    // 5: retarget mid-ramp to a point within one step
    do_reset();
    req(1'b0, 80000);
    repeat (3) frame();
    check("retgt_mid", int'(width_out), 76500);
    req(1'b0, 76200);
    l0 = n_loads;
    frame();
    check("retgt_width", int'(width_out), 76200);
    check("retgt_busy", int'(busy), 0);
    frame();
    check("retgt_loads", n_loads - l0, 1);

    // 6: asynchronous reset mid-ramp
    do_reset();
    req(1'b1, 80000);
    repeat (2) frame();
    @(negedge clk); #2 rst = 1;
    #1;
    check("arst_width", int'(width_out), 75000);
    check("arst_load", int'(width_load), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk); rst = 0;
    model_w = 75000; model_t = 75000;
    l0 = n_loads;
    repeat (5) frame();
    check("arst_no_loads", n_loads - l0, 0);
    check("arst_hold", int'(width_out), 75000);

    // 7: command on the same edge as frame_end steps toward the old target
    req(1'b0, 80000);
    frame();
    @(negedge clk);
    frame_end = 1; req_a = 1; cmd_a = W'(60000);
    model_w = stepf(model_w, model_t);
    exp_q.push_back(model_w);
    @(negedge clk);
    check("overlap_gnt", int'(gnt_a), 1);
    frame_end = 0; req_a = 0;
    model_t = 60000;
    @(negedge clk);
    check("overlap_width", int'(width_out), 76000);
    frame();
    check("overlap_reverse", int'(width_out), 75500);
    ramp_done("overlap", 60000);

    // 4: clamp vectors
    foreach (vecs[i]) begin
      req(vecs[i].is_b, vecs[i].cmd);
      ramp_done($sformatf("vec%0d", i), vecs[i].exp_final);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
